// File: rtl/game_state_rx_if.sv
// Byte-stream link between the link/UART receiver and game_state_rx.
// The receiver drives the master side. game_state_rx consumes the slave side.
interface game_state_rx_if;
  logic [7:0] byte_in;
  logic       byte_valid;

  modport master (output byte_in, output byte_valid);
  modport slave  (input  byte_in, input  byte_valid);
endinterface

// File: rtl/game_state_rx.sv
// Rebuilds renderer buses from game-state packets (SYNC, TYPE, payload, XOR CHK).
// Validated packets are staged and committed to the outputs on the falling edge of vsync.
module game_state_rx #(
  parameter int GAP_TIMEOUT = 50000
) (
  input  logic                  clock,
  input  logic                  reset,
  game_state_rx_if.slave        rx,
  input  logic                  vsync,
  output logic [7:0][12:0][3:0] object_grid,
  output logic [7:0]            time_left,
  output logic [9:0]            point_total,
  output logic [2:0]            game_state,
  output logic [1:0]            num_players,
  output logic [8:0]            player1_x, player1_y,
  output logic [1:0]            player1_direction,
  output logic [3:0]            player1_state,
  output logic [8:0]            player2_x, player2_y,
  output logic [1:0]            player2_direction,
  output logic [3:0]            player2_state,
  output logic [8:0]            player3_x, player3_y,
  output logic [1:0]            player3_direction,
  output logic [3:0]            player3_state,
  output logic [8:0]            player4_x, player4_y,
  output logic [1:0]            player4_direction,
  output logic [3:0]            player4_state,
  output logic                  grid_updated,
  output logic                  status_updated,
  output logic                  rx_error,
  output logic [7:0]            error_count
);

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam logic [7:0] TYPE_GRID   = 8'h01;
  localparam logic [7:0] TYPE_STATUS = 8'h02;
  localparam logic [5:0] GRID_LAST   = 6'd51;
  localparam logic [5:0] STATUS_LAST = 6'd14;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_TYPE    = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;
  localparam logic [1:0] ST_CHK     = 2'd3;

  localparam int              GAP_W    = $clog2(GAP_TIMEOUT + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TIMEOUT - 1);

  typedef struct packed {
    logic [8:0] x;
    logic [8:0] y;
    logic [1:0] dir;
    logic [3:0] state;
  } player_t;

  typedef struct packed {
    player_t [3:0] player;
    logic [7:0]    time_left;
    logic [9:0]    point_total;
    logic [2:0]    game_state;
    logic [1:0]    num_players;
  } status_t;

  logic [1:0]       state;
  logic [5:0]       byte_cnt;
  logic [7:0]       chk;
  logic             is_grid;
  logic [GAP_W-1:0] gap_cnt;
  logic [51:0][7:0] shadow;
  logic [51:0][7:0] grid_stg;
  status_t          status_dec, status_stg, status_out;
  logic             grid_pend, status_pend;
  logic             vsync_q, vsync_qq, commit_evt;
  logic             timeout, err_evt, stage_grid, stage_status;
  logic [5:0]       last_idx;

  assign last_idx   = is_grid ? GRID_LAST : STATUS_LAST;
  assign timeout    = (state != ST_IDLE) && !rx.byte_valid && (gap_cnt == GAP_LAST);
  assign commit_evt = vsync_qq & ~vsync_q;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    err_evt      = 1'b0;
    stage_grid   = 1'b0;
    stage_status = 1'b0;
    if (timeout) begin
      err_evt = 1'b1;
    end else if (rx.byte_valid) begin
      if (state == ST_TYPE && rx.byte_in != TYPE_GRID && rx.byte_in != TYPE_STATUS)
        err_evt = 1'b1;
      if (state == ST_CHK) begin
        if (rx.byte_in == chk) begin
          stage_grid   = is_grid;
          stage_status = !is_grid;
        end else begin
          err_evt = 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      byte_cnt    <= '0;
      chk         <= '0;
      is_grid     <= 1'b0;
      gap_cnt     <= '0;
      rx_error    <= 1'b0;
      error_count <= '0;
    end else begin
      if (timeout) begin
        state   <= ST_IDLE;
        gap_cnt <= '0;
      end else if (rx.byte_valid) begin
        gap_cnt <= '0;
        case (state)
          ST_IDLE: if (rx.byte_in == SYNC_BYTE) state <= ST_TYPE;
          ST_TYPE: begin
            if (rx.byte_in == TYPE_GRID || rx.byte_in == TYPE_STATUS) begin
              state    <= ST_PAYLOAD;
              is_grid  <= (rx.byte_in == TYPE_GRID);
              byte_cnt <= '0;
              chk      <= rx.byte_in;
            end else begin
              state <= ST_IDLE;
            end
          end
          ST_PAYLOAD: begin
            chk      <= chk ^ rx.byte_in;
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == last_idx) state <= ST_CHK;
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state != ST_IDLE) begin
        gap_cnt <= gap_cnt + 1'b1;
      end
      rx_error <= err_evt;
      if (err_evt && error_count != 8'hFF) error_count <= error_count + 1'b1;
    end
  end

  always_comb begin
    status_dec = '0;
    for (int i = 0; i < 4; i++) begin
      status_dec.player[i].x     = {shadow[3*i+2][7], shadow[3*i]};
      status_dec.player[i].y     = {shadow[3*i+2][6], shadow[3*i+1]};
      status_dec.player[i].dir   = shadow[3*i+2][5:4];
      status_dec.player[i].state = shadow[3*i+2][3:0];
    end
    status_dec.time_left   = shadow[12];
    status_dec.point_total = {shadow[14][1:0], shadow[13]};
    status_dec.game_state  = shadow[14][7:5];
    status_dec.num_players = shadow[14][4:3];
  end

  // NOTE: shadow and staged buffers are not reset; pending flags gate their use, so stale data never escapes.
  always_ff @(posedge clock) begin
    if (rx.byte_valid && state == ST_PAYLOAD) shadow[byte_cnt] <= rx.byte_in;
    if (stage_grid)   grid_stg   <= shadow;
    if (stage_status) status_stg <= status_dec;
  end

  // A stage in the commit cycle lands after the clear, so that packet waits for the next vsync.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vsync_q        <= 1'b0;
      vsync_qq       <= 1'b0;
      grid_pend      <= 1'b0;
      status_pend    <= 1'b0;
      object_grid    <= '0;
      status_out     <= '0;
      grid_updated   <= 1'b0;
      status_updated <= 1'b0;
    end else begin
      vsync_q        <= vsync;
      vsync_qq       <= vsync_q;
      grid_updated   <= commit_evt && grid_pend;
      status_updated <= commit_evt && status_pend;
      if (commit_evt && grid_pend) begin
        object_grid <= grid_stg;
        grid_pend   <= 1'b0;
      end
      if (commit_evt && status_pend) begin
        status_out  <= status_stg;
        status_pend <= 1'b0;
      end
      if (stage_grid)   grid_pend   <= 1'b1;
      if (stage_status) status_pend <= 1'b1;
    end
  end

  assign time_left   = status_out.time_left;
  assign point_total = status_out.point_total;
  assign game_state  = status_out.game_state;
  assign num_players = status_out.num_players;

  assign player1_x = status_out.player[0].x;
  assign player1_y = status_out.player[0].y;
  assign player1_direction = status_out.player[0].dir;
  assign player1_state     = status_out.player[0].state;
  assign player2_x = status_out.player[1].x;
  assign player2_y = status_out.player[1].y;
  assign player2_direction = status_out.player[1].dir;
  assign player2_state     = status_out.player[1].state;
  assign player3_x = status_out.player[2].x;
  assign player3_y = status_out.player[2].y;
  assign player3_direction = status_out.player[2].dir;
  assign player3_state     = status_out.player[2].state;
  assign player4_x = status_out.player[3].x;
  assign player4_y = status_out.player[3].y;
  assign player4_direction = status_out.player[3].dir;
  assign player4_state     = status_out.player[3].state;

endmodule
